gemm_c_readback: RTL and testbench

Read-side drain engine for the GEMM output memory C. After the accelerator writes C, this block reads the M×N result words back from the C SRAM in row-major order and streams them out on a valid/ready interface. It sits between `multi_port_memory` (C instance, one read port) and a host or checker. It is the reader counterpart of the accelerator's `sram_c_addr_o`/`sram_c_we_o` write path.

---
 rtl/gemm_c_readback.sv | 244 ++++++++++++++++++++++++
 tb/tb_gemm_c_readback.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_c_readback.sv
// gemm_c_readback: drains the M x N result matrix from the C SRAM in
// row-major order and streams it out over a valid/ready interface.
// A two-entry output FIFO and a credit check keep issue from ever
// overrunning the sink, so data is never dropped under backpressure.
// Optional feature macro: READBACK_CHECKSUM_EN adds a running sum of every
// transferred word on checksum_o; without it checksum_o is tied to zero.
module gemm_c_readback #(
    parameter int OutDataWidth  = 32,
    parameter int AddrWidth     = 12,
    parameter int SizeAddrWidth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    input  logic [AddrWidth-1:0]     base_addr_i,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    input  logic [OutDataWidth-1:0]  sram_c_rdata_i,
    output logic [OutDataWidth-1:0]  out_data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     out_last_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [OutDataWidth-1:0]  checksum_o
);

    localparam int IdxWidth = 2 * SizeAddrWidth;
    localparam logic [IdxWidth-1:0] IdxOne = IdxWidth'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;

    // Job parameters latched at start, plus the running element index.
    logic [IdxWidth-1:0]     total_r;
    logic [IdxWidth-1:0]     idx_r;
    logic [AddrWidth-1:0]    base_r;
    logic [AddrWidth-1:0]    addr_r;

    // One read may be in flight; its data lands in the FIFO next cycle.
    logic                    inflight_r;
    logic                    inflight_last_r;

    // FIFO: the head entry drives the output ports directly, the spare
    // entry absorbs the word that arrives while the head is stalled.
    logic [OutDataWidth-1:0] head_data_r;
    logic                    head_valid_r;
    logic                    head_last_r;
    logic [OutDataWidth-1:0] spare_data_r;
    logic                    spare_valid_r;
    logic                    spare_last_r;

    logic                    busy_r;
    logic                    done_r;

    logic                    start_go_s;
    logic                    size_zero_s;
    logic                    pop_s;
    logic                    push_s;
    logic [1:0]              occ_s;
    logic [1:0]              occ_next_s;
    logic                    credit_ok_s;
    logic                    issue_s;
    logic                    is_last_idx_s;

    // Handshake, credit and issue decisions for the current cycle.
    always_comb begin
        start_go_s    = 1'b0;
        size_zero_s   = 1'b0;
        pop_s         = 1'b0;
        push_s        = 1'b0;
        occ_s         = 2'd0;
        occ_next_s    = 2'd0;
        credit_ok_s   = 1'b0;
        issue_s       = 1'b0;
        is_last_idx_s = 1'b0;

        start_go_s  = (state_r == ST_IDLE) && start_i;
        size_zero_s = (M_size_i == {SizeAddrWidth{1'b0}}) ||
                      (N_size_i == {SizeAddrWidth{1'b0}});
        pop_s       = head_valid_r && out_ready_i;
        push_s      = inflight_r;
        occ_s       = {1'b0, head_valid_r} + {1'b0, spare_valid_r};
        // Occupancy after this cycle; equals occupancy + in-flight - pop,
        // which is also the quantity the credit rule limits.
        occ_next_s  = occ_s + {1'b0, push_s} - {1'b0, pop_s};
        credit_ok_s = (occ_next_s < 2'd2);
        if (state_r == ST_READ) begin
            issue_s = credit_ok_s;
        end else begin
            issue_s = 1'b0;
        end
        is_last_idx_s = (idx_r == (total_r - IdxOne));
    end

    // Next-state selection for the readback sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    if (size_zero_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_READ;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (issue_s && is_last_idx_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                // Nothing is issued here, so an empty FIFO after this
                // cycle also means nothing is left in flight.
                if (occ_next_s == 2'd0) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered busy/done status flags.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Job capture, element index and SRAM read address generation.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            total_r         <= {IdxWidth{1'b0}};
            idx_r           <= {IdxWidth{1'b0}};
            base_r          <= {AddrWidth{1'b0}};
            addr_r          <= {AddrWidth{1'b0}};
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            inflight_r      <= issue_s;
            inflight_last_r <= issue_s && is_last_idx_s;
            if (start_go_s) begin
                total_r <= IdxWidth'(M_size_i) * IdxWidth'(N_size_i);
                idx_r   <= {IdxWidth{1'b0}};
                base_r  <= base_addr_i;
                // The first address is presented in the cycle right after
                // start so the first read can issue immediately.
                addr_r  <= base_addr_i;
            end else if (issue_s && !is_last_idx_s) begin
                idx_r  <= idx_r + IdxOne;
                // Wraps modulo the address space past the top of memory.
                addr_r <= base_r + AddrWidth'(idx_r + IdxOne);
            end
        end
    end

    // Two-entry output FIFO; the head holds steady while the sink stalls.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_data_r   <= {OutDataWidth{1'b0}};
            head_valid_r  <= 1'b0;
            head_last_r   <= 1'b0;
            spare_data_r  <= {OutDataWidth{1'b0}};
            spare_valid_r <= 1'b0;
            spare_last_r  <= 1'b0;
        end else if (!head_valid_r || pop_s) begin
            if (spare_valid_r) begin
                head_data_r   <= spare_data_r;
                head_last_r   <= spare_last_r;
                head_valid_r  <= 1'b1;
                spare_valid_r <= push_s;
                if (push_s) begin
                    spare_data_r <= sram_c_rdata_i;
                    spare_last_r <= inflight_last_r;
                end
            end else if (push_s) begin
                head_data_r  <= sram_c_rdata_i;
                head_last_r  <= inflight_last_r;
                head_valid_r <= 1'b1;
            end else begin
                head_valid_r <= 1'b0;
                head_last_r  <= 1'b0;
            end
        end else if (push_s) begin
            spare_data_r  <= sram_c_rdata_i;
            spare_last_r  <= inflight_last_r;
            spare_valid_r <= 1'b1;
        end
    end

`ifdef READBACK_CHECKSUM_EN
    logic [OutDataWidth-1:0] checksum_r;

    // Wrapping sum of transferred words, cleared on every accepted start.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            checksum_r <= {OutDataWidth{1'b0}};
        end else if (start_go_s) begin
            checksum_r <= {OutDataWidth{1'b0}};
        end else if (pop_s) begin
            checksum_r <= checksum_r + head_data_r;
        end
    end

    assign checksum_o = checksum_r;
`else
    assign checksum_o = {OutDataWidth{1'b0}};
`endif

    assign sram_c_addr_o = addr_r;
    assign out_data_o    = head_data_r;
    assign out_valid_o   = head_valid_r;
    assign out_last_o    = head_last_r;
    assign busy_o        = busy_r;
    assign done_o        = done_r;

endmodule

// File: tb/tb_gemm_c_readback.sv
// Scoreboard bench for gemm_c_readback: jobs push their expected words
// (from a simple memory model indexed row-major with address wrap) into a
// queue, and an independent monitor pops and compares every transferred beat.
module tb_gemm_c_readback;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int SW = 8;
    localparam int MEM_WORDS = 4096;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [SW-1:0] m_size;
    logic [SW-1:0] n_size;
    logic [AW-1:0] base;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_rdata;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;

    logic [DW-1:0] mem [0:MEM_WORDS-1];

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int ready_mode = 0;
    int beats_seen = 0;
    int stall_cnt = 0;
    int first_beat_cyc = 0;
    int last_beat_cyc = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always #5 clk = ~clk;

    gemm_c_readback #(
        .OutDataWidth (DW),
        .AddrWidth    (AW),
        .SizeAddrWidth(SW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .M_size_i      (m_size),
        .N_size_i      (n_size),
        .base_addr_i   (base),
        .sram_c_addr_o (sram_addr),
        .sram_c_rdata_i(sram_rdata),
        .out_data_o    (out_data),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_last_o    (out_last),
        .busy_o        (busy),
        .done_o        (done),
        .checksum_o    (checksum)
    );

    // Synchronous-read SRAM model: data valid the cycle after the address.
    always @(posedge clk) begin
        sram_rdata <= mem[sram_addr];
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sink ready pattern: 0 = always high, 1 = toggling, 2 = random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                2: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every transfer and checks stall hold.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (prev_stall) begin
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_data", {32'd0, out_data}, {32'd0, prev_data});
                chk("hold_last", {63'd0, out_last}, {63'd0, prev_last});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {32'd0, out_data}, 64'hDEAD);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", {32'd0, out_data}, {32'd0, e.data});
                    chk("beat_last", {63'd0, out_last}, {63'd0, e.last});
                end
                beats_seen++;
                if (beats_seen == 1) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
            end
            if (out_valid && !out_ready) stall_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Run one readback job; the start cycle is returned as cycle 0.
    task automatic run_job(input int m, input int n, input logic [AW-1:0] b, output int sc);
        int total;
        int dcyc;
        bit got;
        logic [DW-1:0] sum;
        total = m * n;
        sum = '0;
        dcyc = 0;
        for (int i = 0; i < total; i++) begin
            beat_t e;
            e.data = mem[(int'(b) + i) % MEM_WORDS];
            e.last = (i == total - 1);
            exp_q.push_back(e);
            sum = sum + e.data;
        end
        beats_seen = 0;
        stall_cnt = 0;
        @(posedge clk);
        #1;
        m_size = SW'(m);
        n_size = SW'(n);
        base = b;
        start = 1'b1;
        sc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        m_size = SW'($urandom);
        n_size = SW'($urandom);
        base = AW'($urandom);
        got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                dcyc = cyc - sc;
                chk("busy_with_done", {63'd0, busy}, 64'd1);
            end else if (k == 4 && total >= 8) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_seen", {63'd0, got}, 64'd1);
        if (got) begin
            if (total > 0) begin
                chk("done_cycle", 64'(dcyc), 64'(3 + total + stall_cnt));
            end else begin
                chk("zero_done_cycle", 64'(dcyc), 64'd1);
            end
`ifdef READBACK_CHECKSUM_EN
            chk("checksum", {32'd0, checksum}, {32'd0, sum});
`else
            chk("checksum_off", {32'd0, checksum}, 64'd0);
`endif
            chk("beat_count", 64'(beats_seen), 64'(total));
            chk("queue_drained", 64'(exp_q.size()), 64'd0);
            @(negedge clk);
            chk("done_one_cycle", {63'd0, done}, 64'd0);
            chk("idle_after_done", {63'd0, busy}, 64'd0);
        end
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"}, {52'd0, sram_addr}, 64'd0);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_last"}, {63'd0, out_last}, 64'd0);
        chk({tag, "_data"}, {32'd0, out_data}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_checksum"}, {32'd0, checksum}, 64'd0);
    endtask

    initial begin
        int sc;
        rst_n = 1'b0;
        start = 1'b0;
        m_size = '0;
        n_size = '0;
        base = '0;
        for (int a = 0; a < MEM_WORDS; a++) begin
            mem[a] = {DW'($urandom) & 32'hFFFF_F000} | DW'(a);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed 2x3 job with known data and exact timing.
        for (int i = 0; i < 6; i++) mem[i] = DW'(100 + i);
        ready_mode = 0;
        run_job(2, 3, 12'd0, sc);
        chk("first_beat_cycle", 64'(first_beat_cyc - sc), 64'd3);
        chk("last_beat_cycle", 64'(last_beat_cyc - sc), 64'd8);

        // 4x4 job with toggling ready (stalls add exactly their length).
        ready_mode = 1;
        run_job(4, 4, AW'($urandom), sc);

        // Zero-size job: done in cycle 1, no beats.
        ready_mode = 0;
        run_job(0, 5, 12'd77, sc);

        // Address wrap past the top of memory.
        run_job(1, 4, 12'd4094, sc);

        // Reset in the middle of an 8x8 readback.
        for (int i = 0; i < 64; i++) begin
            beat_t e;
            e.data = mem[(300 + i) % MEM_WORDS];
            e.last = (i == 63);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        m_size = 8'd8;
        n_size = 8'd8;
        base = 12'd300;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_job(1, 1, 12'd500, sc);
        chk("single_first_beat", 64'(first_beat_cyc - sc), 64'd3);

        // Checksum job with a wrapping sum.
        mem[200] = 32'hFFFF_FFFF;
        mem[201] = 32'd1;
        mem[202] = 32'd2;
        mem[203] = 32'd3;
        run_job(2, 2, 12'd200, sc);

        // Randomized jobs under random backpressure.
        ready_mode = 2;
        for (int j = 0; j < 8; j++) begin
            run_job(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), AW'($urandom), sc);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
